// File: rtl/apb_byte_master_if.sv
// APB bus bundle driven by apb_byte_master.
// One-hot 8-way select, 32-bit address and data.
interface apb_byte_master_if;
    logic        presetn;
    logic [7:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;

    modport master (
        output presetn, psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata
    );

    modport slave (
        input  presetn, psel, penable, pwrite, paddr, pwdata,
        output pready, prdata
    );
endinterface

// File: rtl/apb_byte_master.sv
// Byte-wide CPU window that issues 32-bit APB transfers.
// Optional ACCESS timeout abort when APB_TIMEOUT_EN is defined.
module apb_byte_master #(
    parameter logic [15:0] BASE    = 16'hFF00,
    parameter int          TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    input  logic              cpu_we,
    input  logic              cpu_cs,
    output logic [7:0]        cpu_rdata,
    output logic              irq,
    apb_byte_master_if.master apb
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t state, state_nx;

    logic [31:0] wdata_r, rdata_r, pwdata_q;
    logic [15:0] paddr_r, paddr_q;
    logic [2:0]  sel_r, sel_q;
    logic        presetn_q, pwrite_q;
    logic        done, err, ovr, busy;
    logic        hit, wr_hit, rd_hit, cfg_wr, cmd_wr;
    logic        start, complete, abort, tmo_hit;
    logic [3:0]  off;
    logic [7:0]  rd_mux;

    if (BASE[3:0] != 4'h0 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
        $error("apb_byte_master: BASE unaligned or TIMEOUT out of range");
    end

    assign hit    = cpu_cs && (cpu_addr[15:4] == BASE[15:4]);
    assign off    = cpu_addr[3:0];
    assign wr_hit = hit && cpu_we;
    assign rd_hit = hit && !cpu_we;
    assign busy   = (state != IDLE);
    assign cfg_wr = wr_hit && !busy;
    assign cmd_wr = wr_hit && (off == 4'hB);
    assign start  = cmd_wr && !busy && (|cpu_wdata[1:0]);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        complete = 1'b0;
        abort    = 1'b0;
        unique case (state)
            IDLE:   if (start) state_nx = SETUP;
            SETUP:  state_nx = ACCESS;
            ACCESS: begin
                if (apb.pready) begin
                    complete = 1'b1;
                    state_nx = IDLE;
                end else if (tmo_hit) begin
                    abort    = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef APB_TIMEOUT_EN
    logic [7:0] tcnt;

    always_ff @(posedge clk) begin
        if (rst || state == SETUP)  tcnt <= 8'd0;
        else if (state == ACCESS)   tcnt <= tcnt + 8'd1;
    end

    assign tmo_hit = (tcnt == 8'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        rd_mux = 8'h00;
        case (off)
            4'h0, 4'h1, 4'h2, 4'h3:
                rd_mux = wdata_r[{off[1:0], 3'b000} +: 8];
            4'h4, 4'h5, 4'h6, 4'h7:
                rd_mux = rdata_r[{off[1:0], 3'b000} +: 8];
            4'h8:    rd_mux = paddr_r[7:0];
            4'h9:    rd_mux = paddr_r[15:8];
            4'hA:    rd_mux = {5'b0, sel_r};
            4'hB:    rd_mux = {4'b0, ovr, err, done, busy};
            default: rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presetn_q <= 1'b0;
            wdata_r   <= '0;
            rdata_r   <= '0;
            paddr_r   <= '0;
            sel_r     <= '0;
            sel_q     <= '0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            ovr       <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            presetn_q <= 1'b1;
            if (cfg_wr) begin
                case (off)
                    4'h0, 4'h1, 4'h2, 4'h3:
                        wdata_r[{off[1:0], 3'b000} +: 8] <= cpu_wdata;
                    4'h8:    paddr_r[7:0]  <= cpu_wdata;
                    4'h9:    paddr_r[15:8] <= cpu_wdata;
                    4'hA:    sel_r         <= cpu_wdata[2:0];
                    default: ;
                endcase
            end
            if (start) begin
                pwrite_q <= cpu_wdata[0];
                paddr_q  <= paddr_r;
                pwdata_q <= wdata_r;
                sel_q    <= sel_r;
                done     <= 1'b0;
                err      <= 1'b0;
            end
            if (wr_hit && off == 4'hC) begin
                done <= 1'b0;
                err  <= 1'b0;
                ovr  <= 1'b0;
            end
            if (cmd_wr && busy) ovr <= 1'b1;
            // completion is last so it beats a same-cycle clear
            if (complete) begin
                if (!pwrite_q) rdata_r <= apb.prdata;
                done <= 1'b1;
            end
            if (abort) begin
                done <= 1'b1;
                err  <= 1'b1;
            end
            if (rd_hit) cpu_rdata <= rd_mux;
        end
    end

    assign apb.presetn = presetn_q;
    assign apb.psel    = busy ? (8'h01 << sel_q) : 8'h00;
    assign apb.penable = (state == ACCESS);
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = {16'h0000, paddr_q};
    assign apb.pwdata  = pwdata_q;
    assign irq         = done;

endmodule

// File: tb/tb_apb_byte_master.sv
// Randomised bench for apb_byte_master against a register-level model.
// Covers reset, transfers, wait states, collisions, timeout and mid-reset.
module tb_apb_byte_master;

    localparam logic [15:0] BASE = 16'hFF00;
    localparam int          TMO  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_we = 1'b0;
    logic        cpu_cs = 1'b0;
    logic [7:0]  cpu_rdata;
    logic        irq;

    apb_byte_master_if apb ();

    apb_byte_master #(
        .BASE    (BASE),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_cs    (cpu_cs),
        .cpu_rdata (cpu_rdata),
        .irq       (irq),
        .apb       (apb)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model: register file contents and status flags
    logic [31:0] m_wdata, m_rdata, m_lat_data;
    logic [15:0] m_paddr, m_lat_addr;
    logic [2:0]  m_sel, m_lat_sel;
    logic        m_lat_wr;
    logic        m_busy, m_done, m_err, m_ovr;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mdl_clear();
        m_wdata = '0; m_rdata = '0; m_lat_data = '0;
        m_paddr = '0; m_lat_addr = '0;
        m_sel = '0; m_lat_sel = '0; m_lat_wr = 1'b0;
        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
    endtask

    function automatic logic [7:0] mdl_status();
        return {4'b0, m_ovr, m_err, m_done, m_busy};
    endfunction

    function automatic logic [7:0] mdl_read(input logic [3:0] off);
        int b;
        b = int'(off[1:0]) * 8;
        if (off <= 4'h3) return 8'(m_wdata >> b);
        if (off <= 4'h7) return 8'(m_rdata >> b);
        if (off == 4'h8) return m_paddr[7:0];
        if (off == 4'h9) return m_paddr[15:8];
        if (off == 4'hA) return {5'b0, m_sel};
        if (off == 4'hB) return mdl_status();
        return 8'h00;
    endfunction

    task automatic mdl_write(input logic [3:0] off, input logic [7:0] d);
        int b;
        b = int'(off[1:0]) * 8;
        if (off <= 4'hA && off != 4'hB && m_busy) return;
        if (off <= 4'h3) begin
            m_wdata = (m_wdata & ~(32'hFF << b)) | (32'(d) << b);
        end else if (off == 4'h8) begin
            m_paddr[7:0] = d;
        end else if (off == 4'h9) begin
            m_paddr[15:8] = d;
        end else if (off == 4'hA) begin
            m_sel = d[2:0];
        end else if (off == 4'hB) begin
            if (m_busy) begin
                m_ovr = 1'b1;
            end else if (d[1:0] != 2'b00) begin
                m_busy = 1'b1; m_done = 1'b0; m_err = 1'b0;
                m_lat_wr = d[0];
                m_lat_addr = m_paddr;
                m_lat_data = m_wdata;
                m_lat_sel = m_sel;
            end
        end else if (off == 4'hC) begin
            m_done = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
        end
    endtask

    // all cpu ops start at a negedge and take exactly one clock
    task automatic cpu_wr(input logic [3:0] off, input logic [7:0] d);
        cpu_cs = 1'b1; cpu_we = 1'b1;
        cpu_addr = BASE | {12'h000, off};
        cpu_wdata = d;
        @(negedge clk);
        cpu_cs = 1'b0; cpu_we = 1'b0;
        mdl_write(off, d);
    endtask

    task automatic cpu_rd(input logic [3:0] off, output logic [7:0] d);
        cpu_cs = 1'b1; cpu_we = 1'b0;
        cpu_addr = BASE | {12'h000, off};
        @(negedge clk);
        cpu_cs = 1'b0;
        d = cpu_rdata;
    endtask

    function automatic logic [7:0] exp_sel();
        return 8'h01 << m_lat_sel;
    endfunction

    task automatic xfer_start(input logic [7:0] cmd);
        cpu_wr(4'hB, cmd);
        check("setup_psel", apb.psel, exp_sel());
        check("setup_penable", apb.penable, 0);
        check("setup_pwrite", apb.pwrite, m_lat_wr);
        check("setup_paddr", apb.paddr, {16'h0, m_lat_addr});
        check("setup_pwdata", apb.pwdata, m_lat_data);
        @(negedge clk);
    endtask

    task automatic stall(input int n);
        for (int i = 0; i < n; i++) begin
            check("acc_hold", {apb.psel, apb.penable}, {exp_sel(), 1'b1});
            @(negedge clk);
        end
    endtask

    task automatic xfer_finish(input logic [31:0] rd);
        apb.prdata = rd;
        check("acc_penable", apb.penable, 1);
        check("acc_pwdata", apb.pwdata, m_lat_data);
        check("acc_paddr", apb.paddr, {16'h0, m_lat_addr});
        apb.pready = 1'b1;
        @(negedge clk);
        apb.pready = 1'b0;
        m_busy = 1'b0;
        m_done = 1'b1;
        if (!m_lat_wr) m_rdata = rd;
        check("end_bus", {apb.psel, apb.penable}, 0);
        check("end_irq", irq, 1);
    endtask

    logic [7:0]  d, hold;
    logic [3:0]  roff;
    logic [31:0] rd;
    int          waits;

    initial begin
        apb.pready = 1'b0;
        apb.prdata = '0;
        mdl_clear();

        // reset
        repeat (3) @(negedge clk);
        check("rst_presetn", apb.presetn, 0);
        check("rst_psel", apb.psel, 0);
        check("rst_penable", apb.penable, 0);
        check("rst_pwrite", apb.pwrite, 0);
        check("rst_paddr", apb.paddr, 0);
        check("rst_pwdata", apb.pwdata, 0);
        check("rst_irq", irq, 0);
        check("rst_rdata", cpu_rdata, 0);
        rst = 1'b0;
        check("presetn_hold", apb.presetn, 0);
        @(negedge clk);
        check("presetn_rise", apb.presetn, 1);

        // directed write transfer
        cpu_wr(4'h0, 8'hEF); cpu_wr(4'h1, 8'hBE);
        cpu_wr(4'h2, 8'hAD); cpu_wr(4'h3, 8'hDE);
        cpu_wr(4'h8, 8'h10); cpu_wr(4'h9, 8'h00);
        cpu_wr(4'hA, 8'h02);
        xfer_start(8'h01);
        check("wr_psel_const", apb.psel, 8'h04);
        check("wr_pwdata_const", apb.pwdata, 32'hDEADBEEF);
        xfer_finish(32'h0);
        cpu_rd(4'hB, d);
        check("wr_status", d, 8'h02);

        // directed read with four wait states
        cpu_wr(4'hA, 8'h01);
        cpu_wr(4'h8, 8'h04); cpu_wr(4'h9, 8'h00);
        xfer_start(8'h02);
        cpu_rd(4'hB, d);
        check("rd_busy", d, mdl_status());
        stall(3);
        xfer_finish(32'h12345678);
        for (int i = 0; i < 4; i++) begin
            cpu_rd(4'(4 + i), d);
            check("rd_byte", d, mdl_read(4'(4 + i)));
        end
        cpu_rd(4'h4, d);
        check("rd_byte0_const", d, 8'h78);

        // collision while busy
        cpu_wr(4'hC, 8'h00);
        xfer_start(8'h02);
        cpu_wr(4'hB, 8'h01);
        cpu_wr(4'h0, 8'hAA);
        cpu_rd(4'hB, d);
        check("col_status", d, mdl_status());
        check("col_status_const", d, 8'h09);
        xfer_finish(32'hCAFE0001);
        check("col_pwdata", apb.pwdata, m_lat_data);
        cpu_rd(4'hB, d);
        check("col_status_end", d, 8'h0A);
        cpu_rd(4'h0, d);
        check("col_wdata0", d, mdl_read(4'h0));
        cpu_wr(4'hC, 8'h5A);
        check("clr_irq", irq, 0);
        cpu_rd(4'hB, d);
        check("clr_status", d, 8'h00);

        // window decode: out-of-window read holds cpu_rdata
        hold = cpu_rdata;
        cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFE0B;
        @(negedge clk);
        cpu_cs = 1'b0;
        check("miss_hold", cpu_rdata, hold);

        // random register traffic
        for (int n = 0; n < 30; n++) begin
            roff = 4'($urandom_range(0, 15));
            if (roff != 4'hB) cpu_wr(roff, 8'($urandom));
            roff = 4'($urandom_range(0, 15));
            cpu_rd(roff, d);
            check("reg_rd", d, mdl_read(roff));
        end

        // random transfers
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 1) == 1) cpu_wr(4'hC, 8'($urandom));
            for (int b = 0; b < 4; b++) cpu_wr(4'(b), 8'($urandom));
            cpu_wr(4'h8, 8'($urandom));
            cpu_wr(4'h9, 8'($urandom));
            cpu_wr(4'hA, 8'($urandom));
            waits = $urandom_range(0, 5);
            rd = $urandom;
            xfer_start((8'($urandom) & 8'hFC) | 8'($urandom_range(1, 3)));
            if (waits > 0 && $urandom_range(0, 1) == 1) begin
                cpu_rd(4'hB, d);
                check("rnd_busy", d, mdl_status());
                stall(waits - 1);
            end else begin
                stall(waits);
            end
            xfer_finish(rd);
            cpu_rd(4'hB, d);
            check("rnd_status", d, mdl_status());
            roff = 4'($urandom_range(4, 7));
            cpu_rd(roff, d);
            check("rnd_rdata", d, mdl_read(roff));
        end

`ifdef APB_TIMEOUT_EN
        // timeout abort
        cpu_wr(4'hC, 8'h00);
        xfer_start(8'h02);
        stall(TMO);
        m_busy = 1'b0; m_done = 1'b1; m_err = 1'b1;
        check("tmo_psel", apb.psel, 0);
        cpu_rd(4'hB, d);
        check("tmo_status", d, 8'h06);
        cpu_rd(4'h4, d);
        check("tmo_rdata", d, mdl_read(4'h4));
`endif

        // reset during a stalled ACCESS
        xfer_start(8'h01);
        stall(2);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_bus", {apb.psel, apb.penable}, 0);
        check("mrst_presetn", apb.presetn, 0);
        check("mrst_irq", irq, 0);
        rst = 1'b0;
        mdl_clear();
        @(negedge clk);
        cpu_rd(4'hB, d);
        check("mrst_status", d, mdl_status());
        check("mrst_presetn_up", apb.presetn, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
